// File: rtl/rv32_mem_pkg.sv
// ============================================================================
// rv32_mem_pkg : shared encodings for the data-memory responder (rev 1.0)
// ============================================================================
`default_nettype none

package rv32_mem_pkg;

  localparam logic [1:0] WL_BYTE = 2'b00;
  localparam logic [1:0] WL_HALF = 2'b01;
  localparam logic [1:0] WL_WORD = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // wlen 11 is handled as a word, so it shares the word alignment rule.
  function automatic logic is_misaligned(input logic [1:0] wlen, input logic [1:0] addr_lo);
    if (wlen == WL_BYTE) begin
      return 1'b0;
    end else if (wlen == WL_HALF) begin
      return addr_lo[0];
    end else begin
      return (addr_lo != 2'b00);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_steer.sv
// ============================================================================
// dmem_lane_steer : store byte-enable and lane replication from wlen/addr (rev 1.0)
// ============================================================================
`default_nettype none

module dmem_lane_steer
  import rv32_mem_pkg::*;
(
  input  logic [1:0]  i_wlen,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_lane_data
);

  // Data is replicated across lanes so the byte enables alone pick the target lane.
  always_comb begin
    o_be        = 4'b1111;
    o_lane_data = i_wdata;
    case (i_wlen)
      WL_BYTE: begin
        o_be        = 4'b0001 << i_addr_lo;
        o_lane_data = {4{i_wdata[7:0]}};
      end
      WL_HALF: begin
        o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_lane_data = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be        = 4'b1111;
        o_lane_data = i_wdata;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder : fixed-latency valid/ready data-memory responder (rev 1.0)
// Optional misalignment check enabled by defining DMEM_MISALIGN_CHECK_EN.
// ============================================================================
`default_nettype none

module dmem_responder
  import rv32_mem_pkg::*;
#(
  parameter int AW      = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_wlen,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH      = 2 ** AW;
  localparam logic [3:0] C_CNT_INIT = 4'(LATENCY - 1);

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic [AW+1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic [1:0]      r_wlen;
  logic [31:0]     r_rdata;
  logic [31:0]     r_mem [DEPTH];

  logic            w_accept;
  logic            w_in_idle;
  logic            w_we;
  logic [AW+1:0]   w_addr;
  logic [31:0]     w_wdata;
  logic [1:0]      w_wlen;
  logic [AW-1:0]   w_idx;
  logic            w_enter_resp;
  logic            w_misalign;
  logic            w_mem_we;
  logic [3:0]      w_be;
  logic [31:0]     w_lane_data;
  logic            w_unused_addr;

  assign w_unused_addr = ^req_addr[31:AW+2];

  assign req_ready = (r_state == ST_IDLE) & rst;
  assign w_accept  = req_valid & req_ready;
  assign w_in_idle = (r_state == ST_IDLE);

  // With LATENCY=1 the commit edge is the accept edge, so live inputs stand in for the captures.
  assign w_we    = w_in_idle ? req_we              : r_we;
  assign w_addr  = w_in_idle ? req_addr[AW+1:0]    : r_addr;
  assign w_wdata = w_in_idle ? req_wdata           : r_wdata;
  assign w_wlen  = w_in_idle ? req_wlen            : r_wlen;
  assign w_idx   = w_addr[AW+1:2];

  assign w_enter_resp = (w_accept && (LATENCY == 1))
                      || (rst && (r_state == ST_WAIT) && (r_cnt == 4'd1));

`ifdef DMEM_MISALIGN_CHECK_EN
  logic r_err;

  assign w_misalign = is_misaligned(w_wlen, w_addr[1:0]);
  assign rsp_err    = r_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_enter_resp & w_misalign;
    end
  end
`else
  assign w_misalign = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  assign w_mem_we = w_enter_resp & w_we & ~w_misalign;

  dmem_lane_steer u_lane_steer (
    .i_wlen      (w_wlen),
    .i_addr_lo   (w_addr[1:0]),
    .i_wdata     (w_wdata),
    .o_be        (w_be),
    .o_lane_data (w_lane_data)
  );

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
    end else begin
      r_rdata <= 32'd0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr[AW+1:0];
            r_wdata <= req_wdata;
            r_wlen  <= req_wlen;
            if (LATENCY == 1) begin
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= C_CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      if (w_enter_resp) begin
        r_rdata <= (w_we || w_misalign) ? 32'd0 : r_mem[w_idx];
      end
    end
  end

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// tb_dmem_responder : directed + random checks against a transaction-level model (rev 1.0)
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  parameter int AW      = 10;
  parameter int LATENCY = 2;
  localparam int DEPTH  = 2 ** AW;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [1:0]  req_wlen = 2'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.AW(AW), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wlen  (req_wlen),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rsp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit misaligned(input logic [1:0] wl, input logic [1:0] lo);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (wl == 2'b01) return lo[0];
    if (wl[1])       return lo != 2'b00;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // Transaction-level model: one outstanding request, response LATENCY-1 edges after accept.
  logic [31:0] mmem [DEPTH];
  int          edge_n = 0;
  bit          m_pend = 0;
  int          m_resp_edge = 0;
  int          m_busy = 0;
  bit          m_we;
  logic [31:0] m_addr, m_wd;
  logic [1:0]  m_wl;
  bit          exp_valid = 0;
  logic [31:0] exp_rdata = 32'd0;
  bit          exp_err = 0;

  always @(posedge clk) begin
    int i;
    edge_n++;
    exp_valid = 0;
    exp_rdata = 32'd0;
    exp_err   = 0;
    if (!rst) begin
      m_pend = 0;
    end else begin
      if (m_pend && edge_n > m_busy) m_pend = 0;
      if (!m_pend && req_valid) begin
        m_we = req_we; m_addr = req_addr; m_wd = req_wdata; m_wl = req_wlen;
        m_pend = 1;
        m_resp_edge = edge_n + LATENCY - 1;
        m_busy = edge_n + LATENCY;
      end
      if (m_pend && edge_n == m_resp_edge) begin
        i = int'(m_addr[AW+1:2]);
        exp_valid = 1;
        if (misaligned(m_wl, m_addr[1:0])) begin
          exp_err = 1;
        end else if (m_we) begin
          case (m_wl)
            2'b00:   mmem[i][8*int'(m_addr[1:0]) +: 8] = m_wd[7:0];
            2'b01:   mmem[i][16*int'(m_addr[1]) +: 16] = m_wd[15:0];
            default: mmem[i] = m_wd;
          endcase
        end else begin
          exp_rdata = mmem[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    bit exp_ready;
    if (edge_n > 0) begin
      exp_ready = rst && (!m_pend || edge_n >= m_busy);
      chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_err",   {31'd0, rsp_err},   {31'd0, exp_err});
      if (rsp_valid) rsp_cnt++;
    end
  end

  int acc_edge = 0;

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] wl);
    int n;
    bit done;
    n = 0;
    done = 0;
    req_we = we; req_addr = a; req_wdata = wd; req_wlen = wl; req_valid = 1'b1;
    while (!done && n < 50) begin
      done = req_ready;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    acc_edge = edge_n;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL issue_timeout: got no accept expected accept within 50 cycles addr=%h", a);
    end
  endtask

  task automatic wait_rsp(output logic [31:0] d, output bit e, output int at);
    int n;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL rsp_timeout: got no rsp_valid expected rsp_valid within 50 cycles");
    end
    d = rsp_rdata;
    e = rsp_err;
    at = edge_n;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    bit          e;
    int          r, a1, a2, c0, c1;
    logic [31:0] v40;

    // Reset with a request held present
    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF; req_wlen = 2'b10;
    repeat (3) @(negedge clk);
    chk("reset_ready_lit", {31'd0, req_ready}, 32'd0);
    chk("reset_rsp_lit",   32'(rsp_cnt), 32'd0);
    chk("reset_rdata_lit", rsp_rdata, 32'd0);
    req_valid = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 64; i++) issue(1'b1, 32'(i * 4), $urandom, 2'b10);

    // Word store and load
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10);
    a1 = acc_edge;
    wait_rsp(d, e, r);
    chk("t2_store_latency", 32'(r - a1), 32'(LATENCY - 1));
    chk("t2_store_rdata", d, 32'd0);
    issue(1'b0, 32'h10, 32'd0, 2'b10);
    a1 = acc_edge;
    wait_rsp(d, e, r);
    chk("t2_load_latency", 32'(r - a1), 32'(LATENCY - 1));
    chk("t2_load_rdata", d, 32'hDEAD_BEEF);

    // Byte and half lanes
    issue(1'b1, 32'h20, 32'h0, 2'b10);
    issue(1'b1, 32'h23, 32'h0000_00AA, 2'b00);
    issue(1'b1, 32'h20, 32'h0000_1234, 2'b01);
    issue(1'b0, 32'h20, 32'h0, 2'b10);
    wait_rsp(d, e, r);
    chk("t3_lanes", d, 32'hAA00_1234);

    // Wrap and back-to-back accept spacing
    issue(1'b1, 32'h1000, 32'h55, 2'b10);
    a1 = acc_edge;
    issue(1'b0, 32'h0, 32'h0, 2'b10);
    a2 = acc_edge;
    chk("t4_accept_spacing", 32'(a2 - a1), 32'(LATENCY + 1));
    wait_rsp(d, e, r);
    chk("t4_wrap", d, 32'h0000_0055);

    // Reset while a store is pending
    issue(1'b1, 32'h40, 32'h7, 2'b10);
    issue(1'b1, 32'h40, 32'h1, 2'b10);
    #1 rst = 1'b0;
    c0 = rsp_cnt;
    @(negedge clk);
    @(negedge clk);
    #1 c1 = rsp_cnt;
    rst = 1'b1;
    chk("t5_no_rsp", 32'(c1 - c0), 32'd0);
    @(negedge clk);
    v40 = (LATENCY == 1) ? 32'h1 : 32'h7;
    issue(1'b0, 32'h40, 32'h0, 2'b10);
    wait_rsp(d, e, r);
    chk("t5_dropped_store", d, v40);

    // Misaligned word store
    issue(1'b1, 32'h42, 32'hFFFF_FFFF, 2'b10);
    wait_rsp(d, e, r);
`ifdef DMEM_MISALIGN_CHECK_EN
    chk("t6_err", {31'd0, e}, 32'd1);
`else
    chk("t6_err", {31'd0, e}, 32'd0);
    v40 = 32'hFFFF_FFFF;
`endif
    issue(1'b0, 32'h40, 32'h0, 2'b10);
    wait_rsp(d, e, r);
    chk("t6_word40", d, v40);

    // Random traffic over the initialized region, upper address bits scrambled
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      a = ($urandom << (AW + 2)) | (32'($urandom_range(63)) << 2) | 32'($urandom_range(3));
      issue(1'($urandom_range(1)), a, $urandom, 2'($urandom_range(3)));
      if ($urandom_range(15) == 0) begin
        #1 rst = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
      end else begin
        repeat ($urandom_range(2)) @(negedge clk);
      end
    end
    repeat (LATENCY + 3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
